// File: rtl/multicycle_control_unit.sv
// Multi-cycle LEGv8 control unit: sequences fetch/decode/execute/memory/write-back
// and drives the datapath strobes, with a memory-ready handshake and timeout trap.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT     = 16,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] opcode,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        IorD,
  output logic        Reg2Loc,
  output logic        ALUSrcA,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic        instr_done,
  output logic        illegal,
  output logic        mem_err,
  output logic [3:0]  state
);

  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StExecR    = 4'd2;
  localparam logic [3:0] StExecI    = 4'd3;
  localparam logic [3:0] StMemAddr  = 4'd4;
  localparam logic [3:0] StMemLoad  = 4'd5;
  localparam logic [3:0] StMemStore = 4'd6;
  localparam logic [3:0] StWbR      = 4'd7;
  localparam logic [3:0] StWbLoad   = 4'd8;
  localparam logic [3:0] StBranch   = 4'd9;
  localparam logic [3:0] StJump     = 4'd10;
  localparam logic [3:0] StTrap     = 4'd11;

  localparam logic [2:0] ClsR    = 3'd0;
  localparam logic [2:0] ClsAddi = 3'd1;
  localparam logic [2:0] ClsLdur = 3'd2;
  localparam logic [2:0] ClsStur = 3'd3;
  localparam logic [2:0] ClsCbz  = 3'd4;
  localparam logic [2:0] ClsCbnz = 3'd5;
  localparam logic [2:0] ClsB    = 3'd6;
  localparam logic [2:0] ClsIll  = 3'd7;

  localparam int unsigned CntW      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int unsigned TimeoutM1 = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutM1);

  logic [3:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            illegal_q, mem_err_q;
  logic [2:0]      cls;
  logic            wait_st, timeout_hit, set_illegal;

  logic pc_write, ir_write, ior_d, reg2loc, alu_src_a, mem_read, mem_write, mem_to_reg;
  logic reg_write, done;
  logic [1:0] alu_src_b, alu_op, pc_source;

  // First matching pattern wins.
  always_comb begin
    casez (opcode)
      11'b1??0101?000: cls = ClsR;
      11'b1001000100?: cls = ClsAddi;
      11'b11111000010: cls = ClsLdur;
      11'b11111000000: cls = ClsStur;
      11'b10110100???: cls = ClsCbz;
      11'b10110101???: cls = ClsCbnz;
      11'b000101?????: cls = ClsB;
      default:         cls = ClsIll;
    endcase
  end

  assign wait_st = (state_q == StFetch) || (state_q == StMemLoad) || (state_q == StMemStore);
  assign timeout_hit = (MEM_TIMEOUT != 0) && wait_st && !mem_ready && (cnt_q == CntMax);

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    ior_d       = 1'b0;
    reg2loc     = 1'b0;
    alu_src_a   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    done        = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_source   = 2'b00;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        alu_src_b = 2'b11;
        reg2loc   = (cls == ClsStur) || (cls == ClsCbz) || (cls == ClsCbnz);
        case (cls)
          ClsR:                state_d = StExecR;
          ClsAddi:             state_d = StExecI;
          ClsLdur, ClsStur:    state_d = StMemAddr;
          ClsCbz, ClsCbnz:     state_d = StBranch;
          ClsB:                state_d = StJump;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_d     = StTrap;
              set_illegal = 1'b1;
            end else begin
              done    = 1'b1;
              state_d = StFetch;
            end
          end
        endcase
      end
      StExecR: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = StWbR;
      end
      StExecI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StWbR;
      end
      StWbR: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = StFetch;
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        reg2loc   = (cls == ClsStur);
        state_d   = (cls == ClsStur) ? StMemStore : StMemLoad;
      end
      StMemLoad: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
        if (mem_ready) state_d = StWbLoad;
      end
      StWbLoad: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        done       = 1'b1;
        state_d    = StFetch;
      end
      StMemStore: begin
        mem_write = 1'b1;
        ior_d     = 1'b1;
        reg2loc   = 1'b1;
        if (mem_ready) begin
          done    = 1'b1;
          state_d = StFetch;
        end
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        reg2loc   = 1'b1;
        pc_source = 2'b01;
        pc_write  = (cls == ClsCbz) ? zero : !zero;
        done      = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        done      = 1'b1;
        state_d   = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
    if (timeout_hit) state_d = StTrap;
  end

  // Counter only runs while a wait state holds; any transition restarts it.
  assign cnt_d = (wait_st && !mem_ready && (state_d == state_q)) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (set_illegal) illegal_q <= 1'b1;
      if (timeout_hit) mem_err_q <= 1'b1;
    end
  end

  // Reset masks every output, including FETCH's MemRead, in the reset cycle itself.
  assign {PCWrite, IRWrite, IorD, Reg2Loc, ALUSrcA, MemRead, MemWrite, MemtoReg, RegWrite,
          ALUSrcB, ALUOp, PCSource, instr_done} =
         rst ? 16'h0000 : {pc_write, ir_write, ior_d, reg2loc, alu_src_a, mem_read, mem_write,
                           mem_to_reg, reg_write, alu_src_b, alu_op, pc_source, done};
  assign illegal = illegal_q && !rst;
  assign mem_err = mem_err_q && !rst;
  assign state   = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed scenarios plus randomized instruction streams
// checked cycle by cycle against a per-instruction state-path model.
module tb_multicycle_control_unit;

  localparam int FETCH = 0, DECODE = 1, EXEC_R = 2, EXEC_I = 3, MEM_ADDR = 4, MEM_LOAD = 5;
  localparam int MEM_STORE = 6, WB_R = 7, WB_LOAD = 8, BRANCH = 9, JUMP = 10, TRAP = 11;
  localparam int C_R = 0, C_ADDI = 1, C_LDUR = 2, C_STUR = 3, C_CBZ = 4, C_CBNZ = 5, C_B = 6;
  localparam int C_ILL = 7;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ = 11'b10110101000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;
  logic [10:0] opcode = '0;

  // {PCWrite,IRWrite,IorD,Reg2Loc,ALUSrcA,MemRead,MemWrite,MemtoReg,RegWrite,
  //  ALUSrcB,ALUOp,PCSource,instr_done}
  logic [15:0] ov_a, ov_b;
  logic [3:0]  st_a, st_b;
  logic        ill_a, ill_b, merr_a, merr_b;

  int total = 0;
  int bad   = 0;

  logic [10:0] base_tab [7];
  logic [10:0] care_tab [7];

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_TIMEOUT(16), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .PCWrite(ov_a[15]), .IRWrite(ov_a[14]), .IorD(ov_a[13]), .Reg2Loc(ov_a[12]),
    .ALUSrcA(ov_a[11]), .MemRead(ov_a[10]), .MemWrite(ov_a[9]), .MemtoReg(ov_a[8]),
    .RegWrite(ov_a[7]), .ALUSrcB(ov_a[6:5]), .ALUOp(ov_a[4:3]), .PCSource(ov_a[2:1]),
    .instr_done(ov_a[0]), .illegal(ill_a), .mem_err(merr_a), .state(st_a)
  );

  multicycle_control_unit #(.MEM_TIMEOUT(0), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .PCWrite(ov_b[15]), .IRWrite(ov_b[14]), .IorD(ov_b[13]), .Reg2Loc(ov_b[12]),
    .ALUSrcA(ov_b[11]), .MemRead(ov_b[10]), .MemWrite(ov_b[9]), .MemtoReg(ov_b[8]),
    .RegWrite(ov_b[7]), .ALUSrcB(ov_b[6:5]), .ALUOp(ov_b[4:3]), .PCSource(ov_b[2:1]),
    .instr_done(ov_b[0]), .illegal(ill_b), .mem_err(merr_b), .state(st_b)
  );

  function automatic int cls_of(input logic [10:0] op);
    for (int k = 0; k < 7; k++) if ((op & care_tab[k]) == base_tab[k]) return k;
    return C_ILL;
  endfunction

  // Strobe table per state, written straight from the per-state strobe lists.
  function automatic logic [15:0] exp_out(input int st, input int cls, input bit trap,
                                           input logic rdy, input logic z);
    logic pcw = 0, irw = 0, iord = 0, r2l = 0, asa = 0, mr = 0, mw = 0, m2r = 0, rw = 0;
    logic dn = 0;
    logic [1:0] asb = 0, aop = 0, pcs = 0;
    case (st)
      FETCH:     begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      DECODE:    begin
        asb = 2'b11;
        r2l = (cls == C_STUR || cls == C_CBZ || cls == C_CBNZ);
        dn  = (cls == C_ILL) && !trap;
      end
      EXEC_R:    begin asa = 1; aop = 2'b10; end
      EXEC_I:    begin asa = 1; asb = 2'b10; end
      MEM_ADDR:  begin asa = 1; asb = 2'b10; r2l = (cls == C_STUR); end
      MEM_LOAD:  begin mr = 1; iord = 1; end
      MEM_STORE: begin mw = 1; iord = 1; r2l = 1; dn = rdy; end
      WB_R:      begin rw = 1; dn = 1; end
      WB_LOAD:   begin rw = 1; m2r = 1; dn = 1; end
      BRANCH:    begin
        asa = 1; aop = 2'b01; r2l = 1; pcs = 2'b01; dn = 1;
        pcw = (cls == C_CBZ) ? z : !z;
      end
      JUMP:      begin pcs = 2'b10; pcw = 1; dn = 1; end
      default:   ;
    endcase
    return {pcw, irw, iord, r2l, asa, mr, mw, m2r, rw, asb, aop, pcs, dn};
  endfunction

  task automatic step(input logic [10:0] op, input logic rdy, input logic z);
    @(negedge clk);
    opcode = op; mem_ready = rdy; zero = z;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; #1;
    total++; if (ov_a !== 16'h0) begin bad++;
      $display("FAIL reset_strobes got=%h want=0000", ov_a); end
    total++; if ({st_a, ill_a, merr_a} !== 6'd0) begin bad++;
      $display("FAIL reset_state got=%0d/%b/%b want=0/0/0", st_a, ill_a, merr_a); end
    @(posedge clk); #1;
    total++; if (ov_a !== 16'h0 || ov_b !== 16'h0) begin bad++;
      $display("FAIL reset_hold got=%h/%h want=0000", ov_a, ov_b); end
    rst = 1'b0;
    step(OP_ADD, 1'b1, 1'b0);
    total++; if (st_a !== 4'(FETCH) || ov_a !== exp_out(FETCH, C_R, 1, 1'b1, 1'b0)) begin bad++;
      $display("FAIL first_fetch got=%0d/%h want=0/%h", st_a, ov_a,
               exp_out(FETCH, C_R, 1, 1'b1, 1'b0)); end
  endtask

  task automatic test_add();
    int seq [4] = '{FETCH, DECODE, EXEC_R, WB_R};
    int dones = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(OP_ADD, 1'b1, 1'($urandom));
      total++; if (st_a !== 4'(seq[i%4]) || ov_a[7] !== (seq[i%4] == WB_R)) begin bad++;
        $display("FAIL add_seq[%0d] got=%0d rw=%b want=%0d", i, st_a, ov_a[7], seq[i%4]); end
      dones += int'(ov_a[0]);
    end
    total++; if (dones != 2) begin bad++;
      $display("FAIL add_done_count got=%0d want=2", dones); end
  endtask

  task automatic test_ldur_wait();
    int   seq [8] = '{FETCH, DECODE, MEM_ADDR, MEM_LOAD, MEM_LOAD, MEM_LOAD, MEM_LOAD, WB_LOAD};
    logic rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(OP_LDUR, rdy[i], 1'b0);
      total++; if (st_a !== 4'(seq[i])) begin bad++;
        $display("FAIL ldur_seq[%0d] got=%0d want=%0d", i, st_a, seq[i]); end
    end
    total++; if ({ov_a[8], ov_a[7], ov_a[0]} !== 3'b111) begin bad++;
      $display("FAIL ldur_wb got=%b want=111", {ov_a[8], ov_a[7], ov_a[0]}); end
    step(OP_LDUR, 1'b0, 1'b0);
    total++; if (st_a !== 4'(FETCH)) begin bad++;
      $display("FAIL ldur_total got=%0d want=0", st_a); end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 4; k++) begin
      logic [10:0] op = (k < 2) ? OP_CBZ : OP_CBNZ;
      logic z = 1'(k % 2);
      logic want = (k < 2) ? z : !z;
      do_reset();
      for (int i = 0; i < 3; i++) step(op, 1'b1, z);
      total++; if (st_a !== 4'(BRANCH) || ov_a[15] !== want || ov_a[2:1] !== 2'b01) begin bad++;
        $display("FAIL branch[%0d] got st=%0d pcw=%b pcs=%b want st=9 pcw=%b pcs=01",
                 k, st_a, ov_a[15], ov_a[2:1], want); end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    step(11'd0, 1'b1, 1'b0);
    step(11'd0, 1'b1, 1'b0);
    total++; if (ov_a[0] !== 1'b0 || ov_b[0] !== 1'b1) begin bad++;
      $display("FAIL ill_decode_done got=%b/%b want=0/1", ov_a[0], ov_b[0]); end
    step(11'd0, 1'b1, 1'b0);
    total++; if (st_a !== 4'(TRAP) || ill_a !== 1'b1 || st_b !== 4'(FETCH) || ill_b !== 1'b0)
    begin bad++;
      $display("FAIL ill_entry got=%0d/%b %0d/%b want=11/1 0/0", st_a, ill_a, st_b, ill_b); end
    for (int i = 0; i < 5; i++) step(OP_ADD, 1'b1, 1'b1);
    total++; if (st_a !== 4'(TRAP) || ill_a !== 1'b1 || ov_a !== 16'h0) begin bad++;
      $display("FAIL ill_sticky got=%0d/%b/%h want=11/1/0000", st_a, ill_a, ov_a); end
    do_reset();
    total++; if (ill_a !== 1'b0 || st_a !== 4'(FETCH)) begin bad++;
      $display("FAIL ill_clear got=%b/%0d want=0/0", ill_a, st_a); end
  endtask

  task automatic test_timeout();
    int stayed = 1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(OP_ADD, 1'b0, 1'b0);
      if (st_a !== 4'(FETCH)) stayed = 0;
    end
    total++; if (stayed != 1) begin bad++;
      $display("FAIL timeout_early got=left_fetch want=16_cycles_in_fetch"); end
    step(OP_ADD, 1'b0, 1'b0);
    total++; if (st_a !== 4'(TRAP) || merr_a !== 1'b1 || ov_a !== 16'h0) begin bad++;
      $display("FAIL timeout_trap got=%0d/%b/%h want=11/1/0000", st_a, merr_a, ov_a); end
    for (int i = 0; i < 84; i++) step(OP_ADD, 1'b0, 1'b0);
    total++; if (st_b !== 4'(FETCH) || merr_b !== 1'b0 || merr_a !== 1'b1) begin bad++;
      $display("FAIL timeout_disabled got=%0d/%b/%b want=0/0/1", st_b, merr_b, merr_a); end
  endtask

  task automatic test_store_reset();
    do_reset();
    step(OP_STUR, 1'b1, 1'b0);
    step(OP_STUR, 1'b1, 1'b0);
    step(OP_STUR, 1'b1, 1'b0);
    step(OP_STUR, 1'b0, 1'b0);
    total++; if (st_a !== 4'(MEM_STORE) || ov_a[9] !== 1'b1) begin bad++;
      $display("FAIL store_pre got=%0d/%b want=6/1", st_a, ov_a[9]); end
    #1 rst = 1'b1;
    #1;
    total++; if (ov_a[9] !== 1'b0 || st_a !== 4'(FETCH)) begin bad++;
      $display("FAIL store_async got=%b/%0d want=0/0", ov_a[9], st_a); end
    @(posedge clk); #1 rst = 1'b0;
    step(OP_STUR, 1'b0, 1'b0);
    total++; if (st_a !== 4'(FETCH) || ill_a !== 1'b0 || merr_a !== 1'b0) begin bad++;
      $display("FAIL store_after got=%0d/%b/%b want=0/0/0", st_a, ill_a, merr_a); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 40; n++) begin
      int pick = int'($urandom_range(0, 6));
      logic [10:0] op = base_tab[pick] | (11'($urandom) & ~care_tab[pick]);
      int cls = cls_of(op);
      int w1 = int'($urandom_range(0, 3));
      int w2 = int'($urandom_range(0, 3));
      int   sq[$];
      logic rq[$];
      for (int i = 0; i < w1; i++) begin sq.push_back(FETCH); rq.push_back(1'b0); end
      sq.push_back(FETCH); rq.push_back(1'b1);
      sq.push_back(DECODE); rq.push_back(1'($urandom));
      case (cls)
        C_R, C_ADDI: begin
          sq.push_back(cls == C_R ? EXEC_R : EXEC_I); rq.push_back(1'($urandom));
          sq.push_back(WB_R); rq.push_back(1'($urandom));
        end
        C_LDUR, C_STUR: begin
          int ms = (cls == C_LDUR) ? MEM_LOAD : MEM_STORE;
          sq.push_back(MEM_ADDR); rq.push_back(1'($urandom));
          for (int i = 0; i < w2; i++) begin sq.push_back(ms); rq.push_back(1'b0); end
          sq.push_back(ms); rq.push_back(1'b1);
          if (cls == C_LDUR) begin sq.push_back(WB_LOAD); rq.push_back(1'($urandom)); end
        end
        C_CBZ, C_CBNZ: begin sq.push_back(BRANCH); rq.push_back(1'($urandom)); end
        default: begin sq.push_back(JUMP); rq.push_back(1'($urandom)); end
      endcase
      for (int i = 0; i < sq.size(); i++) begin
        logic z = 1'($urandom);
        logic [15:0] e = exp_out(sq[i], cls, 1, rq[i], z);
        step(op, rq[i], z);
        total++; if (st_a !== 4'(sq[i]) || ov_a !== e) begin bad++;
          $display("FAIL rand_a[%0d.%0d] op=%b got=%0d/%h want=%0d/%h",
                   n, i, op, st_a, ov_a, sq[i], e); end
        total++; if (st_b !== 4'(sq[i]) || ov_b !== e) begin bad++;
          $display("FAIL rand_b[%0d.%0d] op=%b got=%0d/%h want=%0d/%h",
                   n, i, op, st_b, ov_b, sq[i], e); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    base_tab = '{11'b10001010000, 11'b10010001000, 11'b11111000010, 11'b11111000000,
                 11'b10110100000, 11'b10110101000, 11'b00010100000};
    care_tab = '{11'b10011110111, 11'b11111111110, 11'b11111111111, 11'b11111111111,
                 11'b11111111000, 11'b11111111000, 11'b11111100000};
    test_reset();
    test_add();
    test_ldur_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_store_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle LEGv8 control unit: a registered state machine that sequences each instruction through fetch, decode, execute, memory and write-back steps. It generates the datapath control strobes per state. It supports R-type, ADDI, LDUR, STUR, CBZ, CBNZ and B, and stalls on a memory ready handshake. It replaces the single-cycle opcode decoder in the datapath when the core is built with shared instruction/data memory.

## Interface
- MEM_TIMEOUT, 16: cycles a memory access may wait with mem_ready=0 before trapping; 0 disables the timeout.
- TRAP_ON_ILLEGAL, 1: 1 = an illegal opcode enters TRAP; 0 = it is retired as a NOP.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  11  instruction[31:21] from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory completes the current read or write this cycle.
- zero  in  1  ALU zero flag.
- PCWrite, IRWrite, IorD, Reg2Loc, ALUSrcA, MemRead, MemWrite, MemtoReg, RegWrite  out  1 each  datapath strobes.
- ALUSrcB  out  2  00=reg B, 01=const 4, 10=sign-extended imm, 11=sign-extended offset<<2.
- ALUOp  out  2  00=add, 01=pass B, 10=funct-decoded.
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- instr_done  out  1  one-cycle pulse in the last state of each instruction.
- illegal  out  1  sticky; illegal opcode trapped.
- mem_err  out  1  sticky; memory timeout trapped.
- state  out  4  current state encoding, for debug.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_LOAD=5, MEM_STORE=6, WB_R=7, WB_LOAD=8, BRANCH=9, JUMP=10, TRAP=11. Encodings 12-15 go to FETCH.
- Decode priority, first match wins:
  - R-type 1xx0101x000
  - ADDI 1001000100x
  - LDUR 11111000010
  - STUR 11111000000
  - CBZ 10110100xxx
  - CBNZ 10110101xxx
  - B 000101xxxxx
  - anything else is illegal.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. When mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE. Otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Reg2Loc=1 for STUR/CBZ/CBNZ.
  - Next state: R→EXEC_R, ADDI→EXEC_I, LDUR/STUR→MEM_ADDR, CBZ/CBNZ→BRANCH, B→JUMP.
  - Illegal→TRAP if TRAP_ON_ILLEGAL=1; otherwise instr_done=1 and go to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then WB_R.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00, then WB_R.
- WB_R: RegWrite=1, MemtoReg=0, instr_done=1, then FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; Reg2Loc=1 for STUR. Next: LDUR→MEM_LOAD, STUR→MEM_STORE.
- MEM_LOAD: MemRead=1, IorD=1. When mem_ready=1, go to WB_LOAD.
- WB_LOAD: RegWrite=1, MemtoReg=1, instr_done=1, then FETCH.
- MEM_STORE: MemWrite=1, IorD=1, Reg2Loc=1. When mem_ready=1: instr_done=1, go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Reg2Loc=1, PCSource=01. PCWrite=zero for CBZ, PCWrite=!zero for CBNZ. instr_done=1, then FETCH.
- JUMP: PCSource=10, PCWrite=1, instr_done=1, then FETCH.
- TRAP: all strobes 0; holds until rst. illegal or mem_err is set on entry and stays sticky.
- Wait counter:
  - Width is clog2(MEM_TIMEOUT+1).
  - Cleared whenever the state changes or mem_ready=1.
  - Increments in FETCH, MEM_LOAD and MEM_STORE while mem_ready=0.
  - When the count reaches MEM_TIMEOUT-1 with mem_ready still 0, the next state is TRAP and mem_err is set.
- Any strobe not listed for a state is 0.

## Timing
- The state register and sticky flags reset asynchronously: state=FETCH, illegal=0, mem_err=0, counter=0.
- While rst=1, all outputs are forced to 0, including FETCH's MemRead. The first FETCH strobes appear in the cycle after rst deasserts.
- Strobes are combinational from state. PCWrite and IRWrite in FETCH, PCWrite in BRANCH, and instr_done in MEM_STORE also depend on the same-cycle inputs (mem_ready or zero).
- Minimum cycles per instruction with mem_ready tied to 1:
  - R-type and ADDI: 4
  - LDUR: 5
  - STUR: 4
  - CBZ, CBNZ and B: 3
  - each memory wait cycle adds 1.
- opcode must be stable from DECODE until the instruction retires. IRWrite is asserted only in FETCH, which guarantees this.
- mem_ready in states other than FETCH, MEM_LOAD and MEM_STORE is ignored.
- rst asserted mid-instruction aborts it immediately; no strobe is asserted in the reset cycle.

## Test plan
- mem_ready=1, opcode=11'b10001011000 (ADD): states 0→1→2→7→0; RegWrite=1 only in WB_R; instr_done pulses once per 4 cycles.
- LDUR 11111000010 with mem_ready held 0 for 3 cycles in MEM_LOAD: dwell is 4 cycles; WB_LOAD has MemtoReg=1 and RegWrite=1; total 8 cycles.
- Branches: CBZ with zero=1 gives PCWrite=1, PCSource=01 in BRANCH. CBZ with zero=0 gives PCWrite=0. CBNZ shows the inverse for both cases.
- opcode=11'b00000000000: with TRAP_ON_ILLEGAL=1, reaches TRAP and illegal=1 persists until rst. With TRAP_ON_ILLEGAL=0, instr_done pulses and FETCH follows.
- MEM_TIMEOUT=16, mem_ready=0 in FETCH: TRAP is entered after exactly 16 cycles in FETCH and mem_err=1. With MEM_TIMEOUT=0 there is no trap after 100 cycles.
- rst pulsed during MEM_STORE: MemWrite drops to 0 asynchronously; after release state=0 and the flags are 0.
